// File: rtl/m_mem_ctrl.sv
// m_mem_ctrl: M-stage load/store sequencer on a req/gnt/rvalid bus; define MISALIGN_EXC_EN to trap misaligned accesses.
// Latency >= 3 cycles (IDLE, REQ, DONE); stalls the pipeline until gnt/rvalid, aborts after MAX_WAIT bus cycles.
module m_mem_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [2:0]  mem_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [2:0]  ext_op,
  output logic [1:0]  ext_a,
  output logic [31:0] ext_din,
  output logic        ld_valid,
  output logic        bus_err,
  output logic        misalign
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_cmd_t;

  logic [1:0] state_q, state_d;
  bus_cmd_t   cmd_q, cmd_d, cmd_new;
  logic [2:0] op_q, op_d;
  logic [1:0] a_q, a_d;
  logic [31:0] din_q, din_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       mis_q, mis_d;

  logic is_byte, is_half, mis_new;
  logic fin, go_wait;

  always_comb begin
    is_byte = (mem_type == 3'b001) || (mem_type == 3'b010);
    is_half = (mem_type == 3'b011) || (mem_type == 3'b100);
  end

  // Lane enables and replicated store data; codes 101-111 fall through to word.
  always_comb begin
    cmd_new.we   = mem_we;
    cmd_new.addr = {addr[31:2], 2'b00};
    if (is_byte) begin
      cmd_new.be    = 4'b0001 << addr[1:0];
      cmd_new.wdata = {4{wdata[7:0]}};
    end else if (is_half) begin
      cmd_new.be    = addr[1] ? 4'b1100 : 4'b0011;
      cmd_new.wdata = {2{wdata[15:0]}};
    end else begin
      cmd_new.be    = 4'b1111;
      cmd_new.wdata = wdata;
    end
  end

`ifdef MISALIGN_EXC_EN
  assign mis_new = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
`else
  assign mis_new = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op_d    = op_q;
    a_d     = a_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mis_d   = mis_q;
    fin     = 1'b0;
    go_wait = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_en) begin
          cmd_d   = cmd_new;
          op_d    = mem_type;
          a_d     = addr[1:0];
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          mis_d   = mis_new;
          state_d = mis_new ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (state_q == ST_REQ) begin
          if (bus_gnt && cmd_q.we) begin
            fin = 1'b1;
          end else if (bus_gnt && bus_rvalid) begin
            fin   = 1'b1;
            din_d = bus_rdata;
          end else if (bus_gnt) begin
            go_wait = 1'b1;
          end
        end else if (bus_rvalid) begin
          fin   = 1'b1;
          din_d = bus_rdata;
        end
        // A completion on the last budgeted cycle still counts as success.
        if (fin) begin
          state_d = ST_DONE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          din_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (go_wait) state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 2'd0;
      din_q   <= 32'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op_q    <= op_d;
      a_q     <= a_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  // stall is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    stall     = reset && ((state_q == ST_IDLE) ? mem_en
                                               : ((state_q == ST_REQ) || (state_q == ST_WAIT)));
    bus_req   = (state_q == ST_REQ);
    bus_we    = cmd_q.we;
    bus_addr  = cmd_q.addr;
    bus_be    = cmd_q.be;
    bus_wdata = cmd_q.wdata;
    ext_op    = op_q;
    ext_a     = a_q;
    ext_din   = din_q;
    ld_valid  = (state_q == ST_DONE) && !cmd_q.we && !err_q && !mis_q;
    bus_err   = (state_q == ST_DONE) && err_q;
    misalign  = (state_q == ST_DONE) && mis_q;
  end

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Directed bench for m_mem_ctrl built with MAX_WAIT=8; expected values are hand-derived per scenario.
module tb_m_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  mem_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic [2:0]  ext_op;
  logic [1:0]  ext_a;
  logic [31:0] ext_din;
  logic        ld_valid;
  logic        bus_err;
  logic        misalign;

  int n_cmp = 0;
  int n_err = 0;

  m_mem_ctrl #(.MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset), .mem_en(mem_en), .mem_we(mem_we), .mem_type(mem_type),
    .addr(addr), .wdata(wdata), .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .ext_op(ext_op), .ext_a(ext_a),
    .ext_din(ext_din), .ld_valid(ld_valid), .bus_err(bus_err), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if ({stall, bus_req, bus_we, ld_valid, bus_err, misalign} !== 6'b0) begin n_err++; $display("FAIL rst_flags: got %b want 000000", {stall, bus_req, bus_we, ld_valid, bus_err, misalign}); end
    n_cmp++; if ({bus_addr, bus_be, bus_wdata} !== 68'h0) begin n_err++; $display("FAIL rst_bus: got %h want 0", {bus_addr, bus_be, bus_wdata}); end
    n_cmp++; if ({ext_op, ext_a, ext_din} !== 37'h0) begin n_err++; $display("FAIL rst_ext: got %h want 0", {ext_op, ext_a, ext_din}); end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    step();
  endtask

  task automatic test_lw_fast();
    mem_en = 1'b1; mem_we = 1'b0; mem_type = 3'b000; addr = 32'h0000_1004; #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lw_stall_idle: got %b want 1", stall); end
    step();
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
    n_cmp++; if ({bus_req, stall} !== 2'b11) begin n_err++; $display("FAIL lw_req_stall: got %b want 11", {bus_req, stall}); end
    n_cmp++; if (bus_addr !== 32'h0000_1004) begin n_err++; $display("FAIL lw_addr: got %h want 00001004", bus_addr); end
    n_cmp++; if (bus_be !== 4'b1111) begin n_err++; $display("FAIL lw_be: got %b want 1111", bus_be); end
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; mem_en = 1'b0; #1;
    n_cmp++; if ({stall, ld_valid, bus_err, bus_req} !== 4'b0100) begin n_err++; $display("FAIL lw_done_flags: got %b want 0100", {stall, ld_valid, bus_err, bus_req}); end
    n_cmp++; if (ext_din !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_ext_din: got %h want deadbeef", ext_din); end
    n_cmp++; if ({ext_op, ext_a} !== 5'b000_00) begin n_err++; $display("FAIL lw_ext_op_a: got %b want 00000", {ext_op, ext_a}); end
    step();
    n_cmp++; if ({ld_valid, stall} !== 2'b00) begin n_err++; $display("FAIL lw_idle_after: got %b want 00", {ld_valid, stall}); end
    n_cmp++; if (ext_din !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_ext_din_hold: got %h want deadbeef", ext_din); end
  endtask

  task automatic test_sb_delayed();
    mem_en = 1'b1; mem_we = 1'b1; mem_type = 3'b001; addr = 32'h0000_2003; wdata = 32'h0000_00A5;
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if ({bus_req, stall, bus_we} !== 3'b111) begin n_err++; $display("FAIL sb_hold_flags[%0d]: got %b want 111", i, {bus_req, stall, bus_we}); end
      n_cmp++; if ({bus_addr, bus_be, bus_wdata} !== {32'h0000_2000, 4'b1000, 32'hA5A5_A5A5}) begin n_err++; $display("FAIL sb_hold_bus[%0d]: got %h %b %h want 00002000 1000 a5a5a5a5", i, bus_addr, bus_be, bus_wdata); end
      step();
    end
    bus_gnt = 1'b1; #1;
    n_cmp++; if ({bus_req, bus_be, bus_wdata} !== {1'b1, 4'b1000, 32'hA5A5_A5A5}) begin n_err++; $display("FAIL sb_gnt_cycle: got %b %b %h want 1 1000 a5a5a5a5", bus_req, bus_be, bus_wdata); end
    step();
    bus_gnt = 1'b0; mem_en = 1'b0; #1;
    n_cmp++; if ({bus_req, stall, ld_valid, bus_err} !== 4'b0000) begin n_err++; $display("FAIL sb_done: got %b want 0000", {bus_req, stall, ld_valid, bus_err}); end
    step();
  endtask

  task automatic test_lh_wait();
    mem_en = 1'b1; mem_we = 1'b0; mem_type = 3'b100; addr = 32'h0000_0012;
    step();
    bus_gnt = 1'b1; #1;
    n_cmp++; if ({bus_addr, bus_be} !== {32'h0000_0010, 4'b1100}) begin n_err++; $display("FAIL lh_bus: got %h %b want 00000010 1100", bus_addr, bus_be); end
    step();
    bus_gnt = 1'b0; #1;
    n_cmp++; if ({bus_req, stall} !== 2'b01) begin n_err++; $display("FAIL lh_wait1: got %b want 01", {bus_req, stall}); end
    step();
    bus_rvalid = 1'b1; bus_rdata = 32'h8001_0000; #1;
    n_cmp++; if ({bus_req, stall} !== 2'b01) begin n_err++; $display("FAIL lh_wait2: got %b want 01", {bus_req, stall}); end
    step();
    bus_rvalid = 1'b0; mem_en = 1'b0; #1;
    n_cmp++; if ({stall, ld_valid} !== 2'b01) begin n_err++; $display("FAIL lh_done: got %b want 01", {stall, ld_valid}); end
    n_cmp++; if ({ext_op, ext_a, ext_din} !== {3'b100, 2'b10, 32'h8001_0000}) begin n_err++; $display("FAIL lh_ext: got %b %b %h want 100 10 80010000", ext_op, ext_a, ext_din); end
    step();
  endtask

  task automatic test_timeout();
    mem_en = 1'b1; mem_we = 1'b0; mem_type = 3'b000; addr = 32'h0000_3000;
    step();
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if ({bus_req, stall} !== 2'b11) begin n_err++; $display("FAIL to_req[%0d]: got %b want 11", i, {bus_req, stall}); end
      step();
    end
    mem_en = 1'b0; #1;
    n_cmp++; if ({bus_req, stall, bus_err, ld_valid} !== 4'b0010) begin n_err++; $display("FAIL to_done: got %b want 0010", {bus_req, stall, bus_err, ld_valid}); end
    n_cmp++; if (ext_din !== 32'h0) begin n_err++; $display("FAIL to_ext_din: got %h want 0", ext_din); end
    step();
    n_cmp++; if ({bus_err, bus_req} !== 2'b00) begin n_err++; $display("FAIL to_idle: got %b want 00", {bus_err, bus_req}); end
  endtask

  task automatic test_timeout_race();
    mem_en = 1'b1; mem_we = 1'b0; mem_type = 3'b000; addr = 32'h0000_3100;
    step();
    repeat (7) step();
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1357_9BDF; #1;
    n_cmp++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL race_req_last: got %b want 1", bus_req); end
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; mem_en = 1'b0; #1;
    n_cmp++; if ({bus_err, ld_valid, ext_din} !== {1'b0, 1'b1, 32'h1357_9BDF}) begin n_err++; $display("FAIL race_done: got %b %b %h want 0 1 13579bdf", bus_err, ld_valid, ext_din); end
    step();
  endtask

  task automatic test_reset_wait();
    mem_en = 1'b1; mem_we = 1'b0; mem_type = 3'b100; addr = 32'h0000_4002;
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    #3 reset = 1'b0; mem_en = 1'b0;
    #1;
    n_cmp++; if ({bus_req, stall, ld_valid, bus_err, bus_we} !== 5'b0) begin n_err++; $display("FAIL rw_flags: got %b want 00000", {bus_req, stall, ld_valid, bus_err, bus_we}); end
    n_cmp++; if ({bus_addr, bus_be, ext_op, ext_a} !== 41'h0) begin n_err++; $display("FAIL rw_regs: got %h want 0", {bus_addr, bus_be, ext_op, ext_a}); end
    @(posedge clk);
    #3 reset = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    step();
    bus_rvalid = 1'b0; #1;
    n_cmp++; if ({bus_req, stall, ld_valid, ext_din} !== {3'b000, 32'h0}) begin n_err++; $display("FAIL rw_late_rvalid: got %b %b %b %h want 0 0 0 0", bus_req, stall, ld_valid, ext_din); end
    step();
    n_cmp++; if ({ld_valid, ext_din} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL rw_after: got %b %h want 0 0", ld_valid, ext_din); end
  endtask

  task automatic test_misalign();
    mem_en = 1'b1; mem_we = 1'b0; mem_type = 3'b000; addr = 32'h0000_1002; #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL mis_idle_req: got %b want 0", bus_req); end
    step();
`ifdef MISALIGN_EXC_EN
    mem_en = 1'b0; #1;
    n_cmp++; if ({misalign, bus_req, ld_valid, stall} !== 4'b1000) begin n_err++; $display("FAIL mis_done: got %b want 1000", {misalign, bus_req, ld_valid, stall}); end
    step();
    n_cmp++; if ({misalign, bus_req} !== 2'b00) begin n_err++; $display("FAIL mis_after: got %b want 00", {misalign, bus_req}); end
`else
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_F00D; #1;
    n_cmp++; if ({bus_req, bus_addr, bus_be} !== {1'b1, 32'h0000_1000, 4'b1111}) begin n_err++; $display("FAIL mis_off_word: got %b %h %b want 1 00001000 1111", bus_req, bus_addr, bus_be); end
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; mem_type = 3'b011; addr = 32'h0000_0013; #1;
    n_cmp++; if ({misalign, ld_valid} !== 2'b01) begin n_err++; $display("FAIL mis_off_done: got %b want 01", {misalign, ld_valid}); end
    step();
    step();
    bus_gnt = 1'b1; bus_rvalid = 1'b1; #1;
    n_cmp++; if ({bus_addr, bus_be} !== {32'h0000_0010, 4'b1100}) begin n_err++; $display("FAIL mis_off_half: got %h %b want 00000010 1100", bus_addr, bus_be); end
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; mem_en = 1'b0; #1;
    n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL mis_off_half_done: got %b want 0", misalign); end
    step();
`endif
  endtask

  task automatic test_lanes();
    mem_en = 1'b1; mem_we = 1'b1; mem_type = 3'b011; addr = 32'h0000_0042; wdata = 32'h1234_ABCD;
    step();
    bus_gnt = 1'b1; #1;
    n_cmp++; if ({bus_we, bus_be, bus_wdata} !== {1'b1, 4'b1100, 32'hABCD_ABCD}) begin n_err++; $display("FAIL sh_bus: got %b %b %h want 1 1100 abcdabcd", bus_we, bus_be, bus_wdata); end
    step();
    bus_gnt = 1'b0; mem_en = 1'b0; #1;
    n_cmp++; if (ld_valid !== 1'b0) begin n_err++; $display("FAIL sh_done_ldv: got %b want 0", ld_valid); end
    step();
    mem_en = 1'b1; mem_we = 1'b0; mem_type = 3'b010; addr = 32'h0000_0061;
    step();
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0000_8000; #1;
    n_cmp++; if ({bus_we, bus_addr, bus_be} !== {1'b0, 32'h0000_0060, 4'b0010}) begin n_err++; $display("FAIL lb_bus: got %b %h %b want 0 00000060 0010", bus_we, bus_addr, bus_be); end
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; mem_en = 1'b0; #1;
    n_cmp++; if ({ext_op, ext_a, ext_din} !== {3'b010, 2'b01, 32'h0000_8000}) begin n_err++; $display("FAIL lb_ext: got %b %b %h want 010 01 00008000", ext_op, ext_a, ext_din); end
    step();
    mem_en = 1'b1; mem_type = 3'b111; addr = 32'h0000_0050;
    step();
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_0001; #1;
    n_cmp++; if (bus_be !== 4'b1111) begin n_err++; $display("FAIL t111_be: got %b want 1111", bus_be); end
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; mem_en = 1'b0; #1;
    n_cmp++; if ({ext_op, ld_valid} !== 4'b1111) begin n_err++; $display("FAIL t111_done: got %b %b want 111 1", ext_op, ld_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    mem_en = 1'b1; mem_we = 1'b0; mem_type = 3'b000; addr = 32'h0000_0070;
    step();
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0070;
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; addr = 32'h0000_0080; #1;
    n_cmp++; if ({bus_req, stall, ld_valid} !== 3'b001) begin n_err++; $display("FAIL b2b_done: got %b want 001", {bus_req, stall, ld_valid}); end
    step();
    n_cmp++; if ({bus_req, stall} !== 2'b01) begin n_err++; $display("FAIL b2b_idle: got %b want 01", {bus_req, stall}); end
    step();
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0080; #1;
    n_cmp++; if ({bus_req, bus_addr} !== {1'b1, 32'h0000_0080}) begin n_err++; $display("FAIL b2b_req2: got %b %h want 1 00000080", bus_req, bus_addr); end
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; mem_en = 1'b0; #1;
    n_cmp++; if ({ld_valid, ext_din} !== {1'b1, 32'h0000_0080}) begin n_err++; $display("FAIL b2b_done2: got %b %h want 1 00000080", ld_valid, ext_din); end
    step();
  endtask

  initial begin
    reset = 1'b0; mem_en = 1'b0; mem_we = 1'b0; mem_type = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    test_reset();
    test_lw_fast();
    test_sb_delayed();
    test_lh_wait();
    test_timeout();
    test_timeout_race();
    test_reset_wait();
    test_misalign();
    test_lanes();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
